// File: rtl/fact_pkg.sv
// Shared constants for the queued factorial engine: register offsets, STATUS fields, FSM states.
// No logic; compile-time definitions only.
// Imported by the engine top and the testbench.
package fact_pkg;

    localparam int          DEF_DATA_W    = 64;
    localparam int          DEF_QDEPTH    = 4;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h7000;

    // Byte offsets inside the 64-byte register window
    localparam logic [5:0] OFF_OPSTART  = 6'h00;
    localparam logic [5:0] OFF_OPCLEAR  = 6'h08;
    localparam logic [5:0] OFF_STATUS   = 6'h10;
    localparam logic [5:0] OFF_INTR_EN  = 6'h18;
    localparam logic [5:0] OFF_OPERAND  = 6'h20;
    localparam logic [5:0] OFF_RESULT_H = 6'h28;
    localparam logic [5:0] OFF_RESULT_L = 6'h30;
    localparam logic [5:0] OFF_RSVD     = 6'h38;

    // STATUS bit positions
    localparam int STB_DONE      = 0;
    localparam int STB_BUSY      = 1;
    localparam int STB_RUN       = 2;
    localparam int STB_OPQ_FULL  = 3;
    localparam int STB_OPQ_EMPTY = 4;
    localparam int STB_OPQ_OVF   = 5;
    localparam int STB_HEAD_OVF  = 6;
    localparam int STB_OPQ_CNT   = 8;
    localparam int STB_RESQ_CNT  = 16;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_WRITE} fsm_state_e;

endpackage

// File: rtl/fact_engine_q_if.sv
// Register bus between a master and the factorial engine, plus the level interrupt.
// Purely combinational wiring; no latency of its own.
// No backpressure: grant is an address decode, the master holds the access as long as it likes.
interface fact_engine_q_if #(parameter int DATA_W = 64) ();
    logic              m_req;
    logic              m_wr;
    logic [15:0]       m_addr;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;
    logic              m_grant;
    logic              interrupt;

    modport master (output m_req, m_wr, m_addr, m_dout, input m_din, m_grant, interrupt);
    modport slave  (input m_req, m_wr, m_addr, m_dout, output m_din, m_grant, interrupt);
endinterface

// File: rtl/fact_fifo.sv
// Synchronous FIFO with flush, occupancy count and show-ahead head data.
// Push visible at head one cycle later; simultaneous push and pop keep the count.
// Push while full and pop while empty are ignored; callers gate them.
module fact_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush returns to the empty state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fact_engine_q.sv
// Queued factorial engine: bus-pushed operands, one multiply per cycle, results queued with overflow flag.
// N>=2 takes N+2 cycles from LOAD to result push, N<2 takes 3; bus reads/grant are combinational.
// Operand push into a full queue is dropped and flagged; the FSM waits while the result queue is full.
module fact_engine_q import fact_pkg::*; #(
    parameter int          DATA_W    = DEF_DATA_W,
    parameter int          RES_W     = 2 * DATA_W,
    parameter int          QDEPTH    = DEF_QDEPTH,
    parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input logic             clk,
    input logic             reset,
    fact_engine_q_if.slave  bus
);
    localparam logic [1:0] IDLE  = S_IDLE;
    localparam logic [1:0] LOAD  = S_LOAD;
    localparam logic [1:0] MUL   = S_MUL;
    localparam logic [1:0] WRITE = S_WRITE;

    logic [1:0]              state;
    logic [RES_W-1:0]        acc;
    logic [DATA_W-1:0]       k;
    logic                    ovf;
    logic                    run;
    logic                    intr_en;
    logic                    opq_ovf;
    logic                    prev_grant;
    logic                    prev_wr;
    logic [15:0]             prev_addr;

    logic                    grant;
    logic [5:0]              off;
    logic                    new_acc;
    logic                    do_clear, do_start, do_ien, do_push_req, do_pop_req;
    logic [RES_W+DATA_W-1:0] prod;
    logic [DATA_W-1:0]       status;
    logic [DATA_W-1:0]       rdata;

    logic                    opq_full, opq_empty;
    logic [$clog2(QDEPTH):0] opq_cnt;
    logic [DATA_W-1:0]       opq_head;
    logic                    resq_full, resq_empty;
    logic [$clog2(QDEPTH):0] resq_cnt;
    logic [RES_W:0]          resq_head;

    // Window decode done 17 bits wide so a window at the top of the map cannot wrap
    assign grant = bus.m_req && ({1'b0, bus.m_addr} >= {1'b0, BASE_ADDR})
                             && ({1'b0, bus.m_addr} <  {1'b0, BASE_ADDR} + 17'd64);
    assign off   = bus.m_addr[5:0] - BASE_ADDR[5:0];

    // Side effects fire once per access; misaligned offsets never match a register
    assign new_acc     = grant && (!prev_grant || (bus.m_wr != prev_wr) || (bus.m_addr != prev_addr));
    assign do_clear    = new_acc && bus.m_wr && (off == OFF_OPCLEAR) && bus.m_dout[0];
    assign do_start    = new_acc && bus.m_wr && (off == OFF_OPSTART) && bus.m_dout[0];
    assign do_ien      = new_acc && bus.m_wr && (off == OFF_INTR_EN);
    assign do_push_req = new_acc && bus.m_wr && (off == OFF_OPERAND);
    assign do_pop_req  = new_acc && !bus.m_wr && (off == OFF_RESULT_L);

    assign prod = {{DATA_W{1'b0}}, acc} * {{RES_W{1'b0}}, k};

    fact_fifo #(.WIDTH(DATA_W), .DEPTH(QDEPTH)) u_opq (
        .clk(clk), .reset(reset), .clr(do_clear),
        .push(do_push_req && !opq_full), .push_dat(bus.m_dout),
        .pop(state == LOAD),
        .full(opq_full), .empty(opq_empty), .count(opq_cnt), .head(opq_head)
    );

    fact_fifo #(.WIDTH(RES_W + 1), .DEPTH(QDEPTH)) u_resq (
        .clk(clk), .reset(reset), .clr(do_clear),
        .push(state == WRITE), .push_dat({ovf, acc}),
        .pop(do_pop_req && !resq_empty),
        .full(resq_full), .empty(resq_empty), .count(resq_cnt), .head(resq_head)
    );

    // Remember the previous bus cycle to detect the start of a new access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_grant <= 1'b0;
            prev_wr    <= 1'b0;
            prev_addr  <= '0;
        end else begin
            prev_grant <= grant;
            prev_wr    <= bus.m_wr;
            prev_addr  <= bus.m_addr;
        end
    end

    // Control bits; clear wipes run and the sticky overflow but keeps intr_en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run     <= 1'b0;
            intr_en <= 1'b0;
            opq_ovf <= 1'b0;
        end else begin
            if (do_clear) begin
                run     <= 1'b0;
                opq_ovf <= 1'b0;
            end else begin
                if (do_start)                run     <= 1'b1;
                if (do_push_req && opq_full) opq_ovf <= 1'b1;
            end
            if (do_ien) intr_en <= bus.m_dout[0];
        end
    end

    // Job sequencer: load an operand, multiply down to 2, then queue the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            k     <= '0;
            ovf   <= 1'b0;
        end else if (do_clear) begin
            state <= IDLE;
            acc   <= '0;
            k     <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (run && !opq_empty && !resq_full) state <= LOAD;
                LOAD: begin
                    k     <= opq_head;
                    acc   <= RES_W'(1);
                    ovf   <= 1'b0;
                    state <= MUL;
                end
                MUL: begin
                    if (k < DATA_W'(2)) begin
                        state <= WRITE;
                    end else begin
                        acc <= prod[RES_W-1:0];
                        k   <= k - 1'b1;
                        ovf <= ovf | (|prod[RES_W+DATA_W-1:RES_W]);
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // STATUS word assembly
    always_comb begin
        status                      = '0;
        status[STB_DONE]            = !resq_empty;
        status[STB_BUSY]            = (state != IDLE);
        status[STB_RUN]             = run;
        status[STB_OPQ_FULL]        = opq_full;
        status[STB_OPQ_EMPTY]       = opq_empty;
        status[STB_OPQ_OVF]         = opq_ovf;
        status[STB_HEAD_OVF]        = !resq_empty && resq_head[RES_W];
        status[STB_OPQ_CNT +: 8]    = 8'(opq_cnt);
        status[STB_RESQ_CNT +: 8]   = 8'(resq_cnt);
    end

    // Read mux; empty result queue reads as zero
    always_comb begin
        rdata = '0;
        if (grant && !bus.m_wr) begin
            case (off)
                OFF_STATUS:   rdata = status;
                OFF_INTR_EN:  rdata = DATA_W'(intr_en);
                OFF_RESULT_H: if (!resq_empty) rdata = DATA_W'(resq_head[RES_W-1:DATA_W]);
                OFF_RESULT_L: if (!resq_empty) rdata = resq_head[DATA_W-1:0];
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.m_grant   = grant;
    assign bus.m_din     = rdata;
    assign bus.interrupt = intr_en && !resq_empty;

endmodule

// File: tb/tb_fact_engine_q.sv
// Self-checking bench for fact_engine_q: table of known factorials, corner sequences, random rounds.
// Expected results come from a plain-arithmetic factorial model and a queue model.
// Bus accesses are one or more cycles long; outputs are sampled mid-cycle.
module tb_fact_engine_q;
    import fact_pkg::*;

    localparam int          DW   = 64;
    localparam int          QD   = 4;
    localparam logic [15:0] BASE = 16'h7000;

    localparam logic [15:0] A_OPSTART  = BASE + 16'(OFF_OPSTART);
    localparam logic [15:0] A_OPCLEAR  = BASE + 16'(OFF_OPCLEAR);
    localparam logic [15:0] A_STATUS   = BASE + 16'(OFF_STATUS);
    localparam logic [15:0] A_INTR_EN  = BASE + 16'(OFF_INTR_EN);
    localparam logic [15:0] A_OPERAND  = BASE + 16'(OFF_OPERAND);
    localparam logic [15:0] A_RESULT_H = BASE + 16'(OFF_RESULT_H);
    localparam logic [15:0] A_RESULT_L = BASE + 16'(OFF_RESULT_L);
    localparam logic [15:0] A_RSVD     = BASE + 16'(OFF_RSVD);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fact_engine_q_if #(.DATA_W(DW)) bus ();

    fact_engine_q #(.DATA_W(DW), .RES_W(2 * DW), .QDEPTH(QD), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] op;
        logic [63:0] exp_h;
        logic [63:0] exp_l;
        logic        exp_ovf;
    } vec_t;

    vec_t        tbl[9];
    logic [63:0] opq_m[$];
    logic [63:0] d;
    logic [63:0] s;
    int          n;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Factorial with 128-bit wraparound and a flag for any lost upper bits
    function automatic logic [128:0] ref_fact(input logic [63:0] num);
        logic [127:0] a;
        logic [191:0] p;
        logic         o;
        a = 128'd1;
        o = 1'b0;
        for (int i = 2; i <= int'(num); i++) begin
            p = {64'd0, a} * 192'(i);
            if (p[191:128] != 0) o = 1'b1;
            a = p[127:0];
        end
        return {o, a};
    endfunction

    task automatic bus_wr(input logic [15:0] a, input logic [63:0] v);
        @(negedge clk);
        bus.m_req = 1'b1; bus.m_wr = 1'b1; bus.m_addr = a; bus.m_dout = v;
        @(negedge clk);
        bus.m_req = 1'b0; bus.m_wr = 1'b0; bus.m_dout = '0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [63:0] v);
        @(negedge clk);
        bus.m_req = 1'b1; bus.m_wr = 1'b0; bus.m_addr = a;
        #1 v = bus.m_din;
        @(negedge clk);
        bus.m_req = 1'b0;
    endtask

    // Count negedges until interrupt rises, giving up after the budget
    task automatic wait_intr(input int budget, output int cnt);
        cnt = 0;
        while (bus.interrupt !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_resq(input string name, input int target, input int budget);
        logic [63:0] st;
        int c;
        c = 0;
        do begin
            bus_rd(A_STATUS, st);
            c++;
        end while (st[23:16] != 8'(target) && c < budget);
        check(name, st[23:16], 128'(target));
    endtask

    task automatic get_result(input string name, input logic [128:0] e);
        logic [63:0] v;
        bus_rd(A_STATUS, v);
        check($sformatf("%s_ovf", name), v[STB_HEAD_OVF], e[128]);
        bus_rd(A_RESULT_H, v);
        check($sformatf("%s_hi", name), v, e[127:64]);
        bus_rd(A_RESULT_L, v);
        check($sformatf("%s_lo", name), v, e[63:0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [128:0] r34, r35;
        r34 = ref_fact(64'd34);
        r35 = ref_fact(64'd35);
        tbl[0] = '{64'd21, 64'd2, 64'd14197454024290336768, 1'b0};
        tbl[1] = '{64'd0,  64'd0, 64'd1,       1'b0};
        tbl[2] = '{64'd1,  64'd0, 64'd1,       1'b0};
        tbl[3] = '{64'd2,  64'd0, 64'd2,       1'b0};
        tbl[4] = '{64'd3,  64'd0, 64'd6,       1'b0};
        tbl[5] = '{64'd5,  64'd0, 64'd120,     1'b0};
        tbl[6] = '{64'd10, 64'd0, 64'd3628800, 1'b0};
        tbl[7] = '{64'd35, r35[127:64], r35[63:0], 1'b1};
        tbl[8] = '{64'd34, r34[127:64], r34[63:0], 1'b0};

        bus.m_req = 1'b0; bus.m_wr = 1'b0; bus.m_addr = '0; bus.m_dout = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_intr", bus.interrupt, 0);
        reset = 1'b0;

        // Combinational decode at the window edges
        @(negedge clk);
        bus.m_req = 1'b1; bus.m_addr = A_RSVD;
        #1 check("grant_top", bus.m_grant, 1);
        check("rsvd_read", bus.m_din, 0);
        bus.m_addr = BASE + 16'h40;
        #1 check("grant_past_end", bus.m_grant, 0);
        bus.m_addr = BASE - 16'h1;
        #1 check("grant_below", bus.m_grant, 0);
        bus.m_req = 1'b0; bus.m_addr = A_STATUS;
        #1 check("din_no_grant", bus.m_din, 0);
        @(negedge clk);
        bus.m_req = 1'b1; bus.m_wr = 1'b1; bus.m_addr = A_STATUS;
        #1 check("din_on_write", bus.m_din, 0);
        bus.m_req = 1'b0; bus.m_wr = 1'b0;

        bus_rd(A_STATUS, s);
        check("reset_status", s, 64'h10);

        // 20! end-to-end with interrupt
        bus_wr(A_OPERAND, 64'd20);
        bus_wr(A_INTR_EN, 64'd1);
        bus_wr(A_OPSTART, 64'd1);
        wait_intr(60, n);
        check("f20_in_budget", 128'(n < 60), 1);
        bus_rd(A_STATUS, s);
        check("f20_status", s, 64'h10015);
        get_result("f20", {1'b0, 64'd0, 64'd2432902008176640000});
        check("f20_intr_after_pop", bus.interrupt, 0);
        bus_rd(A_STATUS, s);
        check("f20_done_after_pop", s[STB_DONE], 0);

        // Table of operands with exact completion latency
        for (int i = 0; i < 9; i++) begin
            bus_wr(A_OPERAND, tbl[i].op);
            wait_intr(100, n);
            check($sformatf("lat_%0d", tbl[i].op), 128'(n),
                  (tbl[i].op < 2) ? 128'd4 : 128'(tbl[i].op + 3));
            get_result($sformatf("tbl_%0d", tbl[i].op), {tbl[i].exp_ovf, tbl[i].exp_h, tbl[i].exp_l});
            check($sformatf("tbl_%0d_intr_clr", tbl[i].op), bus.interrupt, 0);
        end

        // Misaligned accesses do nothing; then overfill the operand queue with run off
        bus_wr(A_OPCLEAR, 64'd1);
        bus_wr(A_OPERAND + 16'h1, 64'd99);
        bus_wr(A_OPSTART + 16'h1, 64'd1);
        bus_rd(A_STATUS, s);
        check("misaligned_noop", s, 64'h10);
        opq_m.delete();
        foreach (tbl[i]) if (i < 5) begin
            logic [63:0] op;
            op = (i == 0) ? 64'd7 : (i == 1) ? 64'd3 : (i == 2) ? 64'd4 : (i == 3) ? 64'd6 : 64'd9;
            if (opq_m.size() < QD) opq_m.push_back(op);
            bus_wr(A_OPERAND, op);
        end
        bus_rd(A_STATUS, s);
        check("opq_full_status", s, 64'h428);
        bus_wr(A_OPSTART, 64'd1);
        wait_resq("fill_resq_cnt", 4, 200);
        while (opq_m.size() > 0) get_result("fill", ref_fact(opq_m.pop_front()));

        // Held RESULT_L read pops once; empty read returns 0
        bus_wr(A_OPERAND, 64'd3);
        bus_wr(A_OPERAND, 64'd4);
        wait_resq("hold_resq_cnt", 2, 100);
        @(negedge clk);
        bus.m_req = 1'b1; bus.m_wr = 1'b0; bus.m_addr = A_RESULT_L;
        #1 check("hold_first_data", bus.m_din, 64'd6);
        repeat (10) @(negedge clk);
        bus.m_req = 1'b0;
        bus_rd(A_STATUS, s);
        check("hold_one_pop", s[23:16], 1);
        bus_rd(A_RESULT_L, d);
        check("hold_second", d, 64'd24);
        bus_rd(A_RESULT_L, d);
        check("empty_read", d, 0);
        bus_rd(A_STATUS, s);
        check("empty_read_cnt", s[23:16], 0);

        // Clear aborts a job in flight
        bus_wr(A_OPERAND, 64'd30);
        repeat (10) @(negedge clk);
        bus_wr(A_OPCLEAR, 64'd1);
        bus_rd(A_STATUS, s);
        check("clear_status", s, 64'h10);
        check("clear_intr", bus.interrupt, 0);
        bus_rd(A_INTR_EN, d);
        check("clear_keeps_ien", d, 1);
        repeat (40) @(negedge clk);
        bus_rd(A_STATUS, s);
        check("clear_no_late_push", s, 64'h10);
        bus_wr(A_OPERAND, 64'd6);
        bus_wr(A_OPSTART, 64'd1);
        wait_intr(60, n);
        get_result("post_clear", ref_fact(64'd6));

        // Random rounds against the queue/factorial model
        for (int r = 0; r < 6; r++) begin
            int cnt;
            logic [63:0] op;
            bus_wr(A_OPCLEAR, 64'd1);
            opq_m.delete();
            cnt = $urandom_range(1, QD);
            if (r % 2 == 1) bus_wr(A_OPSTART, 64'd1);
            for (int i = 0; i < cnt; i++) begin
                op = 64'($urandom_range(0, 40));
                opq_m.push_back(op);
                bus_wr(A_OPERAND, op);
            end
            if (r % 2 == 0) bus_wr(A_OPSTART, 64'd1);
            wait_resq($sformatf("rnd%0d_cnt", r), cnt, 300);
            while (opq_m.size() > 0) begin
                op = opq_m.pop_front();
                get_result($sformatf("rnd%0d_f%0d", r, op), ref_fact(op));
            end
        end

        // Reset mid-job
        bus_wr(A_OPERAND, 64'd30);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_intr", bus.interrupt, 0);
        reset = 1'b0;
        bus_rd(A_STATUS, s);
        check("midreset_status", s, 64'h10);
        bus_rd(A_INTR_EN, d);
        check("midreset_ien", d, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fact_engine_q.md
Name: fact_engine_q

Overview:
Queued, parametrised successor to the single-shot factorial core. It is a bus slave on the m_req/m_wr/m_addr/m_dout/m_din/m_grant interface. Operands are pushed into an operand queue, and the engine computes N! one multiply per cycle. Each result goes into a result queue together with an overflow flag. A level interrupt is raised while results are pending.

Parameters:
DATA_W, 64, bus data width; operand width.
RES_W, 2*DATA_W, result width; split into RESULT_H and RESULT_L.
QDEPTH, 4, depth of both the operand queue and the result queue; must be a power of 2, at most 128.
BASE_ADDR, 16'h7000, base of an 8-register window; registers are 8 bytes apart.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
m_req  in  1  bus request.
m_wr  in  1  1 = write, 0 = read.
m_addr  in  16  byte address.
m_dout  in  DATA_W  write data from the master.
m_grant  out  1  combinational: m_req & (m_addr within BASE_ADDR..BASE_ADDR+0x3F).
m_din  out  DATA_W  combinational read data; 0 when not granted or on a write.
interrupt  out  1  intr_en & result queue non-empty.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 OPSTART, W. bit0=1 sets run.
  - 0x08 OPCLEAR, W. bit0=1 performs a clear.
  - 0x10 STATUS, R.
  - 0x18 INTR_EN, R/W, bit0.
  - 0x20 OPERAND, W. Pushes m_dout.
  - 0x28 RESULT_H, R. Upper DATA_W bits of the head result.
  - 0x30 RESULT_L, R. Lower DATA_W bits of the head result; the read pops the result queue.
  - 0x38 reserved, reads 0.
  - Offsets 0x01-0x07 within a register are ignored, and the access has no effect.
- STATUS layout:
  - bit0 done: result queue non-empty.
  - bit1 busy: FSM not in IDLE.
  - bit2 run.
  - bit3 operand queue full.
  - bit4 operand queue empty.
  - bit5 opq_ovf: sticky.
  - bit6 ovf flag of the head result.
  - [15:8] operand queue count.
  - [23:16] result queue count.
  - All other bits 0.
- Access edge rule: the master holds the bus for many cycles. Side effects (push, pop, start, clear, INTR_EN write) fire only on the first granted cycle of an access. An access is new when the previous cycle was not granted, or when m_wr or m_addr changed. The previous {grant, m_wr, m_addr} is registered for this.
- Reset: run=0, intr_en=0, opq_ovf=0, both queues empty, FSM=IDLE, acc=0, k=0. Outputs: interrupt=0. m_grant and m_din follow the inputs combinationally.
- FSM states:
  - IDLE → LOAD when run & opq non-empty & resq not full.
  - LOAD: pop the operand; k=operand; acc=1; ovf=0; → MUL.
  - MUL: if k<2 → WRITE. Otherwise acc = low RES_W bits of acc*k, k=k-1, and ovf |= (upper product bits != 0).
  - WRITE: push {ovf, acc} into the result queue; → IDLE.
- Latency: N≥2 takes N+2 cycles from LOAD to the WRITE push. N∈{0,1} takes 3 cycles and gives result 1. STATUS.done is visible the cycle after WRITE.
- Arithmetic: the multiplier is RES_W×DATA_W. Only the low RES_W bits are kept; ovf is sticky per job. 34! fits in 128 bits; 35! sets ovf.
- Operand queue full on push: the data is dropped and opq_ovf is set. It is cleared only by OPCLEAR or reset.
- RESULT_L read with an empty result queue returns 0 and does not pop. RESULT_H never pops.
- The FSM pop and a bus push in the same cycle are both honoured, and the count is unchanged. The same applies to a WRITE push and a bus pop on the result queue.
- OPCLEAR takes priority over everything in that cycle:
  - Both queues are flushed; run, opq_ovf, acc and k are cleared.
  - The FSM goes to IDLE, which aborts any job in flight with no push.
  - intr_en is preserved.
- run stays set after the queue drains; the engine resumes as soon as a new operand is pushed.
- Reset asserted mid-job aborts immediately, with the same values as reset.

Decomposition:
- Package fact_pkg holds:
  - register offset constants;
  - STATUS bit positions;
  - the FSM state enum (IDLE, LOAD, MUL, WRITE);
  - the default widths.
- Sub-module fact_fifo: a synchronous FIFO with parameters WIDTH and DEPTH. It has push, pop, full, empty, count and head data, and accepts simultaneous push and pop. It is instantiated twice: the operand queue with WIDTH=DATA_W, and the result queue with WIDTH=RES_W+1.

Test Plan:
1. Reset, then push 20 to OPERAND, write INTR_EN=1, then OPSTART=1 → about 22 cycles later STATUS.done=1 and interrupt=1. RESULT_H=0, RESULT_L=2432902008176640000, ovf=0. After the RESULT_L read, done=0 and interrupt=0.
2. Push 21 → RESULT_H=2, RESULT_L=14197454024290336768. Push 0 and 1 → both results are 1, each 3 cycles after LOAD.
3. Push 35 → STATUS bit6=1 for that result. Then push 34 → bit6=0 for its result.
4. With run=0, push 5 operands (QDEPTH=4) → the count reads 4, full=1 and opq_ovf=1, and the 5th operand is dropped. Set run → results for exactly 4 operands, in order.
5. Hold RESULT_L read for 10 cycles → exactly one pop. RESULT_L read on an empty queue → returns 0 and the count stays 0.
6. Push 30 with run=1, then OPCLEAR 10 cycles later → busy=0 and both queues empty with no result pushed. intr_en is still 1 and interrupt=0. A new push with OPSTART works normally.
